label_overlay_renderer: RTL and testbench

Reader and pixel serializer for the 64x16 text-label bitmap ROM. It takes the VGA timing generator's pixel coordinates, issues row addresses to the ROM, and picks the addressed bit out of the returned 64-bit row. The result is a per-pixel label mask that the colour mux uses to overlay "Simulate" or "Jumps" on the analyzer screen. It accounts for the ROM's one-clock registered read latency and changes the displayed label only at frame boundaries, so a frame never shows half of one label and half of the other.

---
 rtl/label_overlay_renderer.sv | 115 +++++++++++
 tb/tb_label_overlay_renderer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/label_overlay_renderer.sv
// Label overlay renderer: maps VGA pixel coordinates onto rows of the 64x16
// label bitmap ROM and serialises the addressed bit into a per-pixel mask.
// Three-stage pipeline that absorbs the ROM's one-clock registered read.
module label_overlay_renderer #(
    parameter int unsigned X0         = 16,
    parameter int unsigned Y0         = 8,
    parameter int unsigned SCALE_LOG2 = 0,
    parameter int unsigned BLINK_LOG2 = 5
) (
    input  logic        VGA_CLK,
    input  logic        rst_n,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        display_enable,
    input  logic        label_sel,
    input  logic        blink_en,
    output logic [5:0]  rom_address,
    input  logic [63:0] rom_data,
    output logic        pixel_on,
    output logic        pixel_de_out
);

    localparam int unsigned BOX_W  = 32'd64 << SCALE_LOG2;
    localparam int unsigned BOX_H  = 32'd16 << SCALE_LOG2;
    localparam int unsigned FCNT_W = BLINK_LOG2 + 1;
    localparam logic [10:0] X_LO   = 11'(X0);
    localparam logic [10:0] X_HI   = 11'(X0 + BOX_W);
    localparam logic [10:0] Y_LO   = 11'(Y0);
    localparam logic [10:0] Y_HI   = 11'(Y0 + BOX_H);

    // The label box must fit inside the 10-bit coordinate space
    if ((X0 + BOX_W > 1024) || (Y0 + BOX_H > 1024) || (SCALE_LOG2 > 2)) begin : g_bad_cfg
        $error("label_overlay_renderer: label box does not fit the 1024x1024 coordinate space");
    end

    logic [5:0]        rom_address_d, rom_address_q;
    logic [5:0]        col_d1_d, col_d1_q, col_d2_d, col_d2_q;
    logic              hit_d1_d, hit_d1_q, hit_d2_d, hit_d2_q;
    logic              de_d1_d, de_d1_q, de_d2_d, de_d2_q;
    logic              pixel_on_d, pixel_on_q;
    logic              pixel_de_out_d, pixel_de_out_q;
    logic              sel_d, sel_q;
    logic [FCNT_W-1:0] frame_cnt_d, frame_cnt_q;

    logic              in_x, in_y, hit, frame_start, blank;
    logic [9:0]        dx, dy;
    logic [5:0]        col;
    logic [3:0]        row;

    // Box hit test, bitmap coordinates and next-state for every pipeline stage
    always_comb begin
        in_x        = ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI);
        in_y        = ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);
        hit         = display_enable & in_x & in_y;
        dx          = pixel_x - 10'(X0);
        dy          = pixel_y - 10'(Y0);
        col         = 6'(dx >> SCALE_LOG2);
        row         = 4'(dy >> SCALE_LOG2);
        frame_start = (pixel_x == 10'd0) && (pixel_y == 10'd0);
        blank       = blink_en & frame_cnt_q[BLINK_LOG2];

        // Stage 1: issue ROM row address, capture column and qualifiers
        rom_address_d = hit ? {1'b0, sel_q, row} : 6'd0;
        col_d1_d      = col;
        hit_d1_d      = hit & ~blank;
        de_d1_d       = display_enable;

        // Stage 2: wait out the ROM read
        col_d2_d = col_d1_q;
        hit_d2_d = hit_d1_q;
        de_d2_d  = de_d1_q;

        // Stage 3: bit 63 is the leftmost pixel, so index 63-col == ~col
        pixel_on_d     = hit_d2_q & rom_data[~col_d2_q];
        pixel_de_out_d = de_d2_q;

        // Label selection and blink counter only advance at frame start
        sel_d       = frame_start ? label_sel : sel_q;
        frame_cnt_d = frame_start ? frame_cnt_q + FCNT_W'(1) : frame_cnt_q;
    end

    // Pipeline and frame-state registers
    always_ff @(posedge VGA_CLK or negedge rst_n) begin
        if (!rst_n) begin
            rom_address_q  <= '0;
            col_d1_q       <= '0;
            col_d2_q       <= '0;
            hit_d1_q       <= 1'b0;
            hit_d2_q       <= 1'b0;
            de_d1_q        <= 1'b0;
            de_d2_q        <= 1'b0;
            pixel_on_q     <= 1'b0;
            pixel_de_out_q <= 1'b0;
            sel_q          <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            rom_address_q  <= rom_address_d;
            col_d1_q       <= col_d1_d;
            col_d2_q       <= col_d2_d;
            hit_d1_q       <= hit_d1_d;
            hit_d2_q       <= hit_d2_d;
            de_d1_q        <= de_d1_d;
            de_d2_q        <= de_d2_d;
            pixel_on_q     <= pixel_on_d;
            pixel_de_out_q <= pixel_de_out_d;
            sel_q          <= sel_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

    assign rom_address  = rom_address_q;
    assign pixel_on     = pixel_on_q;
    assign pixel_de_out = pixel_de_out_q;

endmodule

// File: tb/tb_label_overlay_renderer.sv
// Bench for label_overlay_renderer: two instances (1x scale / slow blink and
// 2x scale / fast blink) share stimulus and are compared every clock against
// a coordinate-level reference model and a registered ROM model.
module tb_label_overlay_renderer;

    localparam int P_X0 [2] = '{16, 16};
    localparam int P_Y0 [2] = '{8, 8};
    localparam int P_S  [2] = '{0, 1};
    localparam int P_B  [2] = '{5, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  px, py;
    logic        de, lsel, blink;
    logic [5:0]  addr0, addr1;
    logic [63:0] rd0, rd1;
    logic        on0, on1, deo0, deo1;
    logic [63:0] rom [64];

    int n_checks = 0;
    int n_fail   = 0;

    int m_sel  [2];
    int m_fcnt [2];
    bit q_on0[$], q_on1[$], q_de0[$], q_de1[$];

    always #5 clk = ~clk;

    label_overlay_renderer #(.X0(16), .Y0(8), .SCALE_LOG2(0), .BLINK_LOG2(5)) dut0 (
        .VGA_CLK(clk), .rst_n(rst_n), .pixel_x(px), .pixel_y(py),
        .display_enable(de), .label_sel(lsel), .blink_en(blink),
        .rom_address(addr0), .rom_data(rd0), .pixel_on(on0), .pixel_de_out(deo0)
    );

    label_overlay_renderer #(.X0(16), .Y0(8), .SCALE_LOG2(1), .BLINK_LOG2(1)) dut1 (
        .VGA_CLK(clk), .rst_n(rst_n), .pixel_x(px), .pixel_y(py),
        .display_enable(de), .label_sel(lsel), .blink_en(blink),
        .rom_address(addr1), .rom_data(rd1), .pixel_on(on1), .pixel_de_out(deo1)
    );

    // Bitmap ROM with one-clock registered read, one per instance
    always @(posedge clk) begin
        rd0 <= rom[addr0];
        rd1 <= rom[addr1];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected address and mask for one pixel, from the label-box geometry
    function automatic void ref_pix(input int d, input int x, input int y, input bit en,
                                    input int sel, input int fcnt, input bit blk,
                                    output int a, output bit on);
        int w, h, col, row;
        bit hit;
        w   = 64 << P_S[d];
        h   = 16 << P_S[d];
        hit = en && (x >= P_X0[d]) && (x < P_X0[d] + w) && (y >= P_Y0[d]) && (y < P_Y0[d] + h);
        a   = 0;
        on  = 1'b0;
        if (hit) begin
            col = (x - P_X0[d]) >> P_S[d];
            row = (y - P_Y0[d]) >> P_S[d];
            a   = sel * 16 + row;
            on  = !(blk && (((fcnt >> P_B[d]) & 1) == 1)) && (rom[a][63 - col] == 1'b1);
        end
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_sel[d]  = 0;
            m_fcnt[d] = 0;
        end
        q_on0 = '{1'b0, 1'b0};
        q_on1 = '{1'b0, 1'b0};
        q_de0 = '{1'b0, 1'b0};
        q_de1 = '{1'b0, 1'b0};
    endtask

    // Present one pixel (called just after a rising edge), clock it, check outputs
    task automatic step(input int x, input int y, input bit en);
        int  ea [2];
        bit  eo [2];
        bit  e_on, e_de;
        string s;
        px = 10'(x);
        py = 10'(y);
        de = en;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            ref_pix(d, x, y, en, m_sel[d], m_fcnt[d], blink, ea[d], eo[d]);
            if (x == 0 && y == 0) begin
                m_sel[d]  = int'(lsel);
                m_fcnt[d] = (m_fcnt[d] + 1) % (1 << (P_B[d] + 1));
            end
        end
        q_on0.push_back(eo[0]);
        q_on1.push_back(eo[1]);
        q_de0.push_back(en);
        q_de1.push_back(en);
        #1;
        s = $sformatf("(%0d,%0d)", x, y);
        check({"addr0 ", s}, 64'(addr0), 64'(ea[0]));
        check({"addr1 ", s}, 64'(addr1), 64'(ea[1]));
        e_on = q_on0.pop_front();
        e_de = q_de0.pop_front();
        check({"on0 after ", s}, 64'(on0), 64'(e_on));
        check({"de0 after ", s}, 64'(deo0), 64'(e_de));
        e_on = q_on1.pop_front();
        e_de = q_de1.pop_front();
        check({"on1 after ", s}, 64'(on1), 64'(e_on));
        check({"de1 after ", s}, 64'(deo1), 64'(e_de));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1000, 1000, 1'b0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " addr0"}, 64'(addr0), 64'd0);
        check({tag, " addr1"}, 64'(addr1), 64'd0);
        check({tag, " on0"},   64'(on0),   64'd0);
        check({tag, " de0"},   64'(deo0),  64'd0);
        check({tag, " on1"},   64'(on1),   64'd0);
        check({tag, " de1"},   64'(deo1),  64'd0);
    endtask

    initial begin
        for (int r = 0; r < 64; r++) rom[r] = {$urandom, $urandom};
        rom[2][63]  = 1'b0;
        rom[2][62]  = 1'b1;
        rom[18][60] = 1'b1;

        rst_n = 1'b0;
        px = 10'd1000; py = 10'd1000; de = 1'b0; lsel = 1'b0; blink = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        model_reset();

        // Row 2 of "Simulate": col 0 clear, col 1 set
        lsel = 1'b0;
        step(0, 0, 1'b1);
        step(16, 10, 1'b1);
        step(17, 10, 1'b1);
        idle(4);

        // "Jumps" label and horizontal box edges
        lsel = 1'b1;
        step(0, 0, 1'b1);
        step(19, 10, 1'b1);
        step(15, 10, 1'b1);
        step(80, 10, 1'b1);
        step(79, 10, 1'b1);
        step(16, 7, 1'b1);
        step(16, 23, 1'b1);
        step(16, 24, 1'b1);
        step(20, 12, 1'b0);
        idle(4);

        // Mid-frame label_sel change must wait for the next frame start
        lsel = 1'b0;
        step(0, 0, 1'b1);
        lsel = 1'b1;
        step(20, 9, 1'b1);
        step(30, 100, 1'b1);
        step(21, 9, 1'b1);
        step(0, 0, 1'b1);
        step(20, 9, 1'b1);
        step(21, 9, 1'b1);
        idle(4);

        // 2x-scale boundaries
        lsel = 1'b0;
        step(0, 0, 1'b1);
        step(18, 12, 1'b1);
        step(143, 39, 1'b1);
        step(144, 39, 1'b1);
        step(143, 40, 1'b1);
        idle(4);

        // Blink phase over several frames
        blink = 1'b1;
        for (int f = 0; f < 8; f++) begin
            step(0, 0, 1'b1);
            for (int i = 0; i < 6; i++) step(16 + i, 8 + f, 1'b1);
        end
        blink = 1'b0;
        idle(4);

        // Randomised frames
        for (int f = 0; f < 40; f++) begin
            lsel  = 1'($urandom);
            blink = (($urandom % 4) == 0);
            step(0, 0, 1'($urandom));
            for (int i = 0; i < 60; i++) begin
                if (($urandom % 20) == 0) lsel = ~lsel;
                if (($urandom % 30) == 0) blink = ~blink;
                step(int'($urandom_range(0, 200)), int'($urandom_range(0, 60)),
                     (($urandom % 8) != 0));
            end
        end

        // Asynchronous reset in the middle of the label
        blink = 1'b0;
        lsel  = 1'b1;
        step(0, 0, 1'b1);
        for (int i = 0; i < 5; i++) step(16 + i, 12, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async reset");
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("held reset");
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) step(16 + i, 12, 1'b1);
        step(0, 0, 1'b1);
        for (int i = 0; i < 6; i++) step(16 + i, 12, 1'b1);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
